arb_mux_nb: RTL and testbench

- Parametrised, registered N-to-1 data selector with built-in arbitration; the next generation of the 32-bit 8-to-1 select mux.
- Instead of an external select code, the block chooses among NUM_CH requesting channels. It uses fixed-priority or round-robin arbitration and presents the winner on a one-entry registered output with a valid/ready handshake.
- Sits between multiple producers (register-file read ports, ALU/memory result sources) and a single consumer (writeback/bus).

---
 rtl/arb_pkg.sv | 11 +
 rtl/arb_pick.sv | 36 +++
 rtl/arb_mux_nb.sv | 84 ++++++++
 tb/tb_arb_mux_nb.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the arbitrated output mux.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: fixed priority from 0,
// or rotating from ptr with wrap at NUM_CH-1.
module arb_pick
  import arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  arb_mode_t         mode,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);

  always_comb begin
    int start;
    int c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    start = (mode == ARB_RR) ? int'(ptr) : 0;
    c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = start + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && c < NUM_CH && req[c]) begin
        found    = 1'b1;
        idx      = SEL_W'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_nb.sv
// Registered N-to-1 selector with built-in arbitration
// and a one-entry valid/ready output stage.
module arb_mux_nb
  import arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = DEF_WIDTH,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              can_load;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  win;
  logic              found;

  // Reset gates requests so the release edge never grants.
  assign can_load = !out_valid_q || out_ready;
  assign req      = (reset || !can_load) ? '0 : in_valid;

  arb_pick #(
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .mode (arb_mode_t'(mode)),
    .grant(grant),
    .idx  (win),
    .found(found)
  );

  assign in_ready = grant;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (found) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(win)*WIDTH +: WIDTH];
      out_sel_d   = win;
      ptr_d       = (win == SEL_W'(NUM_CH-1)) ? '0 : win + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux_nb.sv
// Directed plus random checks of arb_mux_nb against
// a queue-free arithmetic reference model.
module tb_arb_mux_nb;

  localparam int N = 8;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  arb_mux_nb #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mode     (mode),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] dat [N];
  int           m_ptr;
  logic         m_ov;
  logic [W-1:0] m_od;
  int           m_os;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v,
                                    input logic md, input logic rdy);
    int start;
    if (m_ov && !rdy) return -1;
    start = md ? m_ptr : 0;
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".out_sel"}, 64'(out_sel), 64'(m_os));
    chk({tag, ".out_data"}, 64'(out_data), 64'(m_od));
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input string tag, input logic [N-1:0] v,
                      input logic md, input logic rdy);
    int w;
    logic [63:0] eg;
    in_valid  = v;
    mode      = md;
    out_ready = rdy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
    #1;
    w  = model_pick(v, md, rdy);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk({tag, ".in_ready"}, 64'(in_ready), eg);
    @(posedge clk);
    if (w >= 0) begin
      m_od  = dat[w];
      m_os  = w;
      m_ov  = 1'b1;
      m_ptr = (w + 1) % N;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    #1;
    chk_out(tag);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '1;
    mode      = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < N; i++) dat[i] = 32'hA000_0000 + i;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk_out("rst");
    reset = 1'b0;

    step("first", 8'hFF, 1'b0, 1'b1);
    step("fix0", 8'b1010_0100, 1'b0, 1'b1);
    step("fix1", 8'b1010_0100, 1'b0, 1'b1);
    step("fix2", 8'b1010_0100, 1'b0, 1'b1);

    step("to7", 8'h80, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step("rr_all", 8'hFF, 1'b1, 1'b1);

    step("rr5", 8'h20, 1'b1, 1'b1);
    step("rr_wrap0", 8'h03, 1'b1, 1'b1);
    step("rr_wrap1", 8'h03, 1'b1, 1'b1);

    step("bp_load", 8'h10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("bp_stall", 8'h08, 1'b1, 1'b0);
    step("bp_refill", 8'h08, 1'b1, 1'b1);
    step("drain", 8'h00, 1'b1, 1'b1);

    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < N; i++) dat[i] = $urandom;
      step("rand", N'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    step("pre_rst", 8'hFF, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk_out("arst_hold");
    reset = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = 32'hC0DE_0000 + i;
    step("post_rst7", 8'h80, 1'b1, 1'b1);
    step("post_rst_ptr", 8'h81, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
